// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with a registered head output and full/empty flags
module sync_fifo #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] rptr, wptr, rptr_n, wptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] head_n;
  logic do_push, do_pop;
  assign full    = cnt == CW'(DEPTH);
  assign empty   = cnt == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Next-state pointers and count; the head is forwarded from din when the pushed slot becomes the head.
  always_comb begin
    rptr_n = do_pop ? (rptr == PW'(DEPTH - 1) ? '0 : rptr + 1'b1) : rptr;
    wptr_n = do_push ? (wptr == PW'(DEPTH - 1) ? '0 : wptr + 1'b1) : wptr;
    cnt_n  = cnt + CW'(do_push) - CW'(do_pop);
    head_n = cnt_n == '0 ? '0 : (do_push && rptr_n == wptr) ? din : mem[rptr_n];
  end
  // Pointer, count and registered head update.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      dout <= '0;
    end else begin
      rptr <= rptr_n;
      wptr <= wptr_n;
      cnt  <= cnt_n;
      dout <= head_n;
    end
  end
  // Storage write; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/dsp_aw_channel.sv
// dsp_aw_channel: steers AW to the decoded slave and queues slave IDs to route W bursts
module dsp_aw_channel #(
  parameter int SLV_AMT         = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int SLV_ID_W        = $clog2(SLV_AMT),
  parameter int SLV_ID_MSB_IDX  = 30,
  parameter int SLV_ID_LSB_IDX  = 30,
  parameter int OUTSTANDING_AMT = 8
) (
  input  logic                           ACLK_i,
  input  logic                           ARESET_i,
  input  logic [ADDR_WIDTH-1:0]          m_AWADDR_i,
  input  logic                           m_AWVALID_i,
  output logic                           m_AWREADY_o,
  output logic [ADDR_WIDTH*SLV_AMT-1:0]  sa_AWADDR_o,
  output logic [SLV_AMT-1:0]             sa_AWVALID_o,
  input  logic [SLV_AMT-1:0]             sa_AWREADY_i,
  input  logic                           m_WVALID_i,
  input  logic                           m_WLAST_i,
  input  logic                           m_WREADY_i,
  output logic [SLV_ID_W-1:0]            dsp_WDATA_slv_id_o,
  output logic                           dsp_WDATA_disable_o
);
  localparam int FW = SLV_ID_MSB_IDX - SLV_ID_LSB_IDX + 1;
  logic [FW-1:0] field;
  logic [SLV_AMT-1:0] sel;
  logic full, empty, push, pop;
  // Decode the slave ID; an out-of-range ID shifts the one-hot select to zero, stalling the AW.
  always_comb begin
    field        = m_AWADDR_i[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX];
    sel          = SLV_AMT'(1) << field;
    sa_AWADDR_o  = {SLV_AMT{m_AWADDR_i}};
    sa_AWVALID_o = {SLV_AMT{m_AWVALID_i & ~full}} & sel;
    m_AWREADY_o  = |(sa_AWREADY_i & sel) & ~full;
    push         = m_AWVALID_i & m_AWREADY_o;
    pop          = m_WVALID_i & m_WREADY_i & m_WLAST_i;
  end
  assign dsp_WDATA_disable_o = empty;
  sync_fifo #(.DATA_W(SLV_ID_W), .DEPTH(OUTSTANDING_AMT)) u_id_fifo (
    .clk   (ACLK_i),
    .rst   (ARESET_i),
    .push  (push),
    .pop   (pop),
    .din   (SLV_ID_W'(field)),
    .dout  (dsp_WDATA_slv_id_o),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_dsp_aw_channel.sv
// tb_dsp_aw_channel: vector table for AW steering plus scoreboarded ID queue sequences
module tb_dsp_aw_channel;
  logic clk = 0, rst = 0;
  logic [31:0] awaddr = 0;
  logic awvalid = 0, awready;
  logic [63:0] sa_addr;
  logic [1:0] sa_valid, sa_ready = 0;
  logic wvalid = 0, wlast = 0, wready = 0;
  logic slv_id, dis;
  int n_cmp = 0, n_bad = 0;
  logic sb [$];
  typedef struct {
    logic [31:0] addr;
    logic        v;
    logic [1:0]  rdy;
    logic [1:0]  esa;
    logic        er;
  } vec_t;
  vec_t vt [6];

  dsp_aw_channel #(.SLV_AMT(2), .ADDR_WIDTH(32), .SLV_ID_MSB_IDX(30), .SLV_ID_LSB_IDX(30),
                   .OUTSTANDING_AMT(4)) dut (
    .ACLK_i(clk), .ARESET_i(rst), .m_AWADDR_i(awaddr), .m_AWVALID_i(awvalid),
    .m_AWREADY_o(awready), .sa_AWADDR_o(sa_addr), .sa_AWVALID_o(sa_valid),
    .sa_AWREADY_i(sa_ready), .m_WVALID_i(wvalid), .m_WLAST_i(wlast), .m_WREADY_i(wready),
    .dsp_WDATA_slv_id_o(slv_id), .dsp_WDATA_disable_o(dis));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic aw(input logic id);
    awaddr = {1'b0, id, 30'h0};
    awvalid = 1;
    sa_ready = 2'b11;
    #1;
    chk("aw_ready", awready, sb.size() < 4);
    chk("aw_valid", sa_valid, sb.size() < 4 ? (id ? 2'b10 : 2'b01) : 2'b00);
    if (sb.size() < 4) sb.push_back(id);
    tick();
    awvalid = 0;
  endtask

  task automatic wl;
    chk("w_disable", dis, sb.size() == 0);
    if (sb.size() != 0) chk("w_head", slv_id, sb[0]);
    wvalid = 1; wlast = 1; wready = 1;
    tick();
    wvalid = 0; wlast = 0; wready = 0;
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic drain;
    while (sb.size() != 0) wl();
    #1;
    chk("drained_disable", dis, 1);
    chk("drained_id", slv_id, 0);
  endtask

  initial begin
    vt[0] = '{32'h0000_0000, 1, 2'b11, 2'b01, 1};
    vt[1] = '{32'h4000_0000, 1, 2'b10, 2'b10, 1};
    vt[2] = '{32'h4000_0000, 1, 2'b01, 2'b10, 0};
    vt[3] = '{32'h0000_0000, 0, 2'b11, 2'b00, 1};
    vt[4] = '{32'h0000_1234, 1, 2'b10, 2'b01, 0};
    vt[5] = '{32'hC000_0010, 1, 2'b10, 2'b10, 1};
    rst = 1;
    tick();
    rst = 0;
    chk("rst_disable", dis, 1);
    chk("rst_id", slv_id, 0);
    sa_ready = 2'b11; awaddr = 0;
    #1;
    chk("rst_awready", awready, 1);
    foreach (vt[i]) begin
      awaddr = vt[i].addr; awvalid = vt[i].v; sa_ready = vt[i].rdy;
      #1;
      chk($sformatf("vec%0d_sa_valid", i), sa_valid, vt[i].esa);
      chk($sformatf("vec%0d_awready", i), awready, vt[i].er);
      chk($sformatf("vec%0d_sa_addr", i), sa_addr, {2{vt[i].addr}});
    end
    awvalid = 0;
    tick();
    chk("table_no_push", dis, 1);
    // routing
    awaddr = 32'h4000_0000; awvalid = 1; sa_ready = 2'b10;
    #1;
    chk("route_sa_valid", sa_valid, 2'b10);
    chk("route_awready", awready, 1);
    sb.push_back(1);
    tick();
    awvalid = 0;
    chk("route_id", slv_id, 1);
    chk("route_disable", dis, 0);
    // fill to full and probe the stalled fifth AW
    aw(0); aw(1); aw(0);
    awaddr = 32'h4000_0000; awvalid = 1; sa_ready = 2'b11;
    #1;
    chk("full_awready", awready, 0);
    chk("full_sa_valid", sa_valid, 2'b00);
    awvalid = 0;
    wl();
    awvalid = 1;
    #1;
    chk("after_pop_awready", awready, 1);
    awvalid = 0;
    drain();
    // pop rules
    aw(1); aw(0);
    wvalid = 1; wready = 1; wlast = 0;
    tick();
    chk("nonlast_head", slv_id, 1);
    wlast = 1; wready = 0;
    tick();
    chk("noready_head", slv_id, 1);
    wvalid = 0; wlast = 0;
    wl();
    chk("pop_head", slv_id, 0);
    // simultaneous push and pop with two entries {0,1}
    aw(1);
    awaddr = 32'h0; awvalid = 1; sa_ready = 2'b11;
    wvalid = 1; wlast = 1; wready = 1;
    #1;
    chk("simul_awready", awready, 1);
    chk("simul_head_before", slv_id, sb[0]);
    tick();
    awvalid = 0; wvalid = 0; wlast = 0; wready = 0;
    void'(sb.pop_front());
    sb.push_back(0);
    chk("simul_head_after", slv_id, 1);
    wl();
    chk("simul_one_left", dis, 0);
    drain();
    // reset mid-operation
    aw(1); aw(0); aw(1);
    rst = 1;
    tick();
    rst = 0;
    sb.delete();
    chk("mid_rst_disable", dis, 1);
    chk("mid_rst_id", slv_id, 0);
    wl();
    chk("mid_rst_nopop", dis, 1);
    aw(1); aw(0); aw(1); aw(0);
    chk("post_rst_full_id", slv_id, 1);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
